// File: rtl/cpu_regfile_sb.sv
// cpu_regfile_sb
// Register file plus outstanding-write scoreboard for the moxie core.
// It sits just after writeback and feeds operands back to decode/execute.
//
// Ports:
//   clk_i                   clock; all state changes on the rising edge
//   rst_i                   asynchronous reset, active low
//   register_write_index_i  writeback destination register
//   register_we_i           writeback enable; also retires one reservation
//   result_i                writeback data
//   reserve_i               issue reserves a pending write ...
//   reserve_index_i         ... to this register
//   flush_i                 drop every reservation (register writes still land)
//   reg0_index_i            read port 0 source register
//   reg1_index_i            read port 1 source register
//   value0_o                read port 0 data, one cycle latency, write-first bypass
//   value1_o                read port 1 data, one cycle latency, write-first bypass
//   hazard_o                combinational: a source still waits on a pending write
//   overflow_o              sticky: a reservation hit a saturated counter
module cpu_regfile_sb #(
    parameter int NREGS = 16,
    parameter int CNTW  = 2,
    localparam int IW   = $clog2(NREGS)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [IW-1:0] register_write_index_i,
    input  logic          register_we_i,
    input  logic [31:0]   result_i,
    input  logic          reserve_i,
    input  logic [IW-1:0] reserve_index_i,
    input  logic          flush_i,
    input  logic [IW-1:0] reg0_index_i,
    input  logic [IW-1:0] reg1_index_i,
    output logic [31:0]   value0_o,
    output logic [31:0]   value1_o,
    output logic          hazard_o,
    output logic          overflow_o
);

    logic [31:0]                regs [NREGS];
    logic [NREGS-1:0][CNTW-1:0] cnt;
    logic [NREGS-1:0]           res;
    logic [NREGS-1:0]           ret;
    logic [NREGS-1:0]           ovf_req;

    // ------------------------------------------------------------------
    // Register storage: every register is writable, no hard-wired zero.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (register_we_i) begin
            regs[register_write_index_i] <= result_i;
        end
    end

    // ------------------------------------------------------------------
    // Read ports: a same-cycle writeback to the read index wins, so the
    // consumer sees the new value at the very next edge.
    // ------------------------------------------------------------------
    logic byp0, byp1;
    assign byp0 = register_we_i && (register_write_index_i == reg0_index_i);
    assign byp1 = register_we_i && (register_write_index_i == reg1_index_i);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            value0_o <= '0;
            value1_o <= '0;
        end else begin
            value0_o <= byp0 ? result_i : regs[reg0_index_i];
            value1_o <= byp1 ? result_i : regs[reg1_index_i];
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard: one saturating up/down counter per register.
    // A reserve and a retire on the same register cancel out.
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NREGS; g++) begin : g_sb
        logic sat;
        assign res[g] = reserve_i     && (reserve_index_i        == IW'(g));
        assign ret[g] = register_we_i && (register_write_index_i == IW'(g));
        assign sat    = &cnt[g];
        // Flush discards the reservation, so it cannot overflow either.
        assign ovf_req[g] = !flush_i && res[g] && !ret[g] && sat;

        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                cnt[g] <= '0;
            end else if (flush_i) begin
                cnt[g] <= '0;
            end else if (res[g] && !ret[g]) begin
                if (!sat) cnt[g] <= cnt[g] + 1'b1;
            end else if (ret[g] && !res[g]) begin
                // An unreserved writeback is legal; hold at zero.
                if (cnt[g] != '0) cnt[g] <= cnt[g] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) overflow_o <= 1'b0;
        else if (|ovf_req) overflow_o <= 1'b1;
    end

    // ------------------------------------------------------------------
    // Hazard: a source is blocked while its counter is non-zero, unless
    // this cycle's writeback retires the last pending write (the value then
    // arrives through the bypass). Same-cycle reservations and flush do
    // not affect the current cycle's hazard.
    // ------------------------------------------------------------------
    logic hz0, hz1;
    assign hz0 = (cnt[reg0_index_i] != '0) &&
                 !(byp0 && (cnt[reg0_index_i] == CNTW'(1)));
    assign hz1 = (cnt[reg1_index_i] != '0) &&
                 !(byp1 && (cnt[reg1_index_i] == CNTW'(1)));
    assign hazard_o = hz0 | hz1;

endmodule

// File: tb/tb_cpu_regfile_sb.sv
module tb_cpu_regfile_sb;

    localparam int CMAX = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  widx, ridx, r0, r1;
    logic        we, res, flush;
    logic [31:0] wdata;
    logic [31:0] value0, value1;
    logic        hazard, overflow;

    always #5 clk = ~clk;

    cpu_regfile_sb dut (
        .clk_i                  (clk),
        .rst_i                  (rst_n),
        .register_write_index_i (widx),
        .register_we_i          (we),
        .result_i               (wdata),
        .reserve_i              (res),
        .reserve_index_i        (ridx),
        .flush_i                (flush),
        .reg0_index_i           (r0),
        .reg1_index_i           (r1),
        .value0_o               (value0),
        .value1_o               (value1),
        .hazard_o               (hazard),
        .overflow_o             (overflow)
    );

    typedef struct {
        logic        hz;
        logic [31:0] v0;
        logic [31:0] v1;
        logic        ovf;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic        hz_obs;
    int          checks = 0;
    int          errors = 0;

    // reference model of architectural state
    logic [31:0] mregs [16];
    int          mcnt  [16];
    logic        movf;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            mregs[i] = '0;
            mcnt[i]  = 0;
        end
        movf = 1'b0;
        sb.delete();
    endtask

    // Drive one cycle of stimulus, sample the combinational hazard, push the
    // model's expectation, then advance past the edge.
    task automatic cyc(input logic i_we, input logic [3:0] i_widx, input logic [31:0] i_wd,
                       input logic i_res, input logic [3:0] i_ridx, input logic i_flush,
                       input logic [3:0] i_r0, input logic [3:0] i_r1);
        exp_t x;
        bit rs, rt;
        @(negedge clk);
        we = i_we; widx = i_widx; wdata = i_wd;
        res = i_res; ridx = i_ridx; flush = i_flush;
        r0 = i_r0; r1 = i_r1;
        #1;
        hz_obs = hazard;
        x.hz = ((mcnt[i_r0] != 0) && !(i_we && i_widx == i_r0 && mcnt[i_r0] == 1)) ||
               ((mcnt[i_r1] != 0) && !(i_we && i_widx == i_r1 && mcnt[i_r1] == 1));
        x.v0 = (i_we && i_widx == i_r0) ? i_wd : mregs[i_r0];
        x.v1 = (i_we && i_widx == i_r1) ? i_wd : mregs[i_r1];
        for (int i = 0; i < 16; i++) begin
            rs = i_res && (i_ridx == 4'(i));
            rt = i_we && (i_widx == 4'(i));
            if (i_flush) mcnt[i] = 0;
            else if (rs && !rt) begin
                if (mcnt[i] == CMAX) movf = 1'b1;
                else mcnt[i]++;
            end else if (rt && !rs && mcnt[i] > 0) mcnt[i]--;
        end
        if (i_we) mregs[i_widx] = i_wd;
        x.ovf = movf;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [3:0] a, input logic [3:0] b);
        cyc(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 1'b0, a, b);
    endtask

    task automatic test_reset();
        rd(4'd0, 4'd15);
        e = sb.pop_front();
        checks++; if (hz_obs !== e.hz) begin errors++; $display("FAIL reset_hz got %b exp %b", hz_obs, e.hz); end
        checks++; if (value0 !== 32'd0) begin errors++; $display("FAIL reset_v0 got %h exp 0", value0); end
        checks++; if (value1 !== 32'd0) begin errors++; $display("FAIL reset_v1 got %h exp 0", value1); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", overflow); end
    endtask

    task automatic test_bypass();
        cyc(1'b1, 4'd3, 32'h12345678, 1'b0, 4'd0, 1'b0, 4'd3, 4'd3);
        e = sb.pop_front();
        checks++; if (value0 !== e.v0 || value0 !== 32'h12345678) begin errors++; $display("FAIL bypass_v0 got %h exp %h", value0, e.v0); end
        checks++; if (value1 !== e.v1 || value1 !== 32'h12345678) begin errors++; $display("FAIL bypass_v1 got %h exp %h", value1, e.v1); end
        rd(4'd3, 4'd0);
        e = sb.pop_front();
        checks++; if (value0 !== 32'h12345678) begin errors++; $display("FAIL reread_v0 got %h exp %h", value0, 32'h12345678); end
        checks++; if (value1 !== e.v1) begin errors++; $display("FAIL reread_v1 got %h exp %h", value1, e.v1); end
    endtask

    task automatic test_stall();
        cyc(1'b0, 4'd0, 32'd0, 1'b1, 4'd7, 1'b0, 4'd7, 4'd7);
        e = sb.pop_front();
        checks++; if (hz_obs !== 1'b0) begin errors++; $display("FAIL stall_same_cycle_hz got %b exp 0", hz_obs); end
        rd(4'd7, 4'd0);
        e = sb.pop_front();
        checks++; if (hz_obs !== 1'b1) begin errors++; $display("FAIL stall_hz got %b exp 1", hz_obs); end
        cyc(1'b1, 4'd7, 32'hA5A5A5A5, 1'b0, 4'd0, 1'b0, 4'd7, 4'd0);
        e = sb.pop_front();
        checks++; if (hz_obs !== 1'b0) begin errors++; $display("FAIL unstall_hz got %b exp 0", hz_obs); end
        checks++; if (value0 !== 32'hA5A5A5A5) begin errors++; $display("FAIL unstall_v0 got %h exp %h", value0, 32'hA5A5A5A5); end
    endtask

    task automatic test_multi();
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 4'd0, 32'd0, 1'b1, 4'd2, 1'b0, 4'd0, 4'd0);
            void'(sb.pop_front());
        end
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 4'd2, 32'h100 + k, 1'b0, 4'd0, 1'b0, 4'd2, 4'd0);
            e = sb.pop_front();
            checks++; if (hz_obs !== e.hz || hz_obs !== (k < 2)) begin errors++; $display("FAIL multi_retire%0d_hz got %b exp %b", k, hz_obs, e.hz); end
            checks++; if (value0 !== e.v0) begin errors++; $display("FAIL multi_retire%0d_v0 got %h exp %h", k, value0, e.v0); end
        end
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 4'd0, 32'd0, 1'b1, 4'd2, 1'b0, 4'd0, 4'd0);
            e = sb.pop_front();
            checks++; if (overflow !== e.ovf || overflow !== (k == 3)) begin errors++; $display("FAIL multi_ovf%0d got %b exp %b", k, overflow, e.ovf); end
        end
        rd(4'd2, 4'd2);
        e = sb.pop_front();
        checks++; if (hz_obs !== 1'b1) begin errors++; $display("FAIL multi_sat_hz got %b exp 1", hz_obs); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL multi_ovf_sticky got %b exp 1", overflow); end
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 4'd2, 32'h200 + k, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0);
            void'(sb.pop_front());
        end
        rd(4'd2, 4'd0);
        e = sb.pop_front();
        checks++; if (hz_obs !== 1'b0) begin errors++; $display("FAIL multi_drain_hz got %b exp 0", hz_obs); end
    endtask

    task automatic test_simul();
        cyc(1'b0, 4'd0, 32'd0, 1'b1, 4'd4, 1'b0, 4'd0, 4'd0);
        void'(sb.pop_front());
        cyc(1'b1, 4'd4, 32'h44, 1'b1, 4'd4, 1'b0, 4'd0, 4'd4);
        e = sb.pop_front();
        checks++; if (hz_obs !== e.hz) begin errors++; $display("FAIL simul_hz got %b exp %b", hz_obs, e.hz); end
        checks++; if (value1 !== 32'h44) begin errors++; $display("FAIL simul_v1 got %h exp %h", value1, 32'h44); end
        rd(4'd4, 4'd0);
        e = sb.pop_front();
        checks++; if (hz_obs !== 1'b1) begin errors++; $display("FAIL simul_next_hz got %b exp 1", hz_obs); end
        cyc(1'b1, 4'd9, 32'h99, 1'b0, 4'd0, 1'b0, 4'd9, 4'd0);
        e = sb.pop_front();
        checks++; if (hz_obs !== 1'b0) begin errors++; $display("FAIL unres_hz got %b exp 0", hz_obs); end
        rd(4'd9, 4'd9);
        e = sb.pop_front();
        checks++; if (hz_obs !== 1'b0) begin errors++; $display("FAIL unres_cnt_hz got %b exp 0", hz_obs); end
        checks++; if (value1 !== 32'h99) begin errors++; $display("FAIL unres_v1 got %h exp %h", value1, 32'h99); end
        cyc(1'b1, 4'd4, 32'h45, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0);
        void'(sb.pop_front());
    endtask

    task automatic test_flush();
        cyc(1'b0, 4'd0, 32'd0, 1'b1, 4'd1, 1'b0, 4'd0, 4'd0);
        void'(sb.pop_front());
        cyc(1'b0, 4'd0, 32'd0, 1'b1, 4'd6, 1'b0, 4'd0, 4'd0);
        void'(sb.pop_front());
        cyc(1'b1, 4'd6, 32'h55, 1'b0, 4'd0, 1'b1, 4'd1, 4'd6);
        e = sb.pop_front();
        checks++; if (hz_obs !== 1'b1) begin errors++; $display("FAIL flush_same_cycle_hz got %b exp 1", hz_obs); end
        rd(4'd1, 4'd6);
        e = sb.pop_front();
        checks++; if (hz_obs !== 1'b0) begin errors++; $display("FAIL flush_hz got %b exp 0", hz_obs); end
        checks++; if (value1 !== 32'h55) begin errors++; $display("FAIL flush_v1 got %h exp %h", value1, 32'h55); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 300; k++) begin
            cyc(1'($urandom_range(0, 1)), 4'($urandom), $urandom,
                1'($urandom_range(0, 2) == 0), 4'($urandom_range(0, 5)),
                1'($urandom_range(0, 40) == 0),
                4'($urandom_range(0, 5)), 4'($urandom));
            e = sb.pop_front();
            checks++;
            if (hz_obs !== e.hz || value0 !== e.v0 || value1 !== e.v1 || overflow !== e.ovf) begin
                errors++;
                $display("FAIL b2b[%0d] got hz=%b v0=%h v1=%h ovf=%b exp hz=%b v0=%h v1=%h ovf=%b",
                         k, hz_obs, value0, value1, overflow, e.hz, e.v0, e.v1, e.ovf);
            end
        end
    endtask

    task automatic test_async_reset();
        cyc(1'b1, 4'd5, 32'hDEADBEEF, 1'b1, 4'd8, 1'b0, 4'd5, 4'd0);
        void'(sb.pop_front());
        rd(4'd8, 4'd5);
        e = sb.pop_front();
        checks++; if (hz_obs !== 1'b1) begin errors++; $display("FAIL prereset_hz got %b exp 1", hz_obs); end
        checks++; if (value1 !== 32'hDEADBEEF) begin errors++; $display("FAIL prereset_v1 got %h exp %h", value1, 32'hDEADBEEF); end
        @(negedge clk);
        we = 1'b0; res = 1'b0; flush = 1'b0; r0 = 4'd8; r1 = 4'd5;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (value0 !== 32'd0 || value1 !== 32'd0) begin errors++; $display("FAIL areset_vals got %h/%h exp 0/0", value0, value1); end
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL areset_hz got %b exp 0", hazard); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL areset_ovf got %b exp 0", overflow); end
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rd(4'd5, 4'd8);
        e = sb.pop_front();
        checks++; if (value0 !== 32'd0 || value0 !== e.v0) begin errors++; $display("FAIL postreset_r5 got %h exp 0", value0); end
        checks++; if (hz_obs !== 1'b0) begin errors++; $display("FAIL postreset_hz got %b exp 0", hz_obs); end
    endtask

    initial begin
        rst_n = 1'b0;
        we = 1'b0; widx = '0; wdata = '0; res = 1'b0; ridx = '0;
        flush = 1'b0; r0 = '0; r1 = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_bypass();
        test_stall();
        test_multi();
        test_simul();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_regfile_sb.md
# cpu_regfile_sb

Register file and write scoreboard for the moxie core, sitting directly downstream of the writeback unit and feeding operands back to decode/execute. Holds the 16 x 32-bit general registers, accepts the writeback unit's single write port (index, enable, result), and provides two registered read ports with same-cycle write bypass. A per-register outstanding-write scoreboard, reserved at issue and retired by writeback, produces the operand hazard (stall) signal.

## Interface
Parameters:
- NREGS, 16, number of general registers (index width 4)
- CNTW, 2, width of each per-register outstanding-write counter (max 3 pending)

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset, asynchronous, active-low
- register_write_index_i  in  4  writeback destination index
- register_we_i  in  1  writeback write enable; also retires one reservation
- result_i  in  32  writeback data
- reserve_i  in  1  issue stage reserves a pending write
- reserve_index_i  in  4  register being reserved
- flush_i  in  1  pipeline flush; clears all reservations
- reg0_index_i  in  4  read port 0 index
- reg1_index_i  in  4  read port 1 index
- value0_o  out  32  read port 0 data, registered
- value1_o  out  32  read port 1 data, registered
- hazard_o  out  1  combinational: a requested source register has a pending write not satisfied this cycle
- overflow_o  out  1  sticky: reservation attempted on a saturated counter

## Operation
- Write: register_we_i=1 writes result_i into regs[register_write_index_i] at the clock edge. All 16 registers are writable (no hard-wired zero).
- Read: each edge, value0_o <= regs[reg0_index_i], value1_o <= regs[reg1_index_i]. When register_we_i=1 and register_write_index_i equals a read index, that port captures result_i (write-first bypass).
- Scoreboard: cnt[i] is a CNTW-bit counter per register. Per edge, for each i:
  - res = reserve_i && reserve_index_i==i; ret = register_we_i && register_write_index_i==i.
  - flush_i=1: cnt[i] <= 0 for all i (overrides res/ret). Register writes still occur.
  - res && ret: unchanged.
  - res only: +1. When cnt[i]==3, the count stays 3 and overflow_o is set.
  - ret only: -1. When cnt[i]==0, the count stays 0 (an unreserved write is legal).
- Hazard: for port p, hz_p = cnt[idx_p]!=0 && !(ret at idx_p && cnt[idx_p]==1). hazard_o = hz_0 | hz_1. A reservation made this cycle does not affect hazard_o until the next cycle. flush_i does not mask hazard_o in the current cycle.
- overflow_o clears only on reset.

## Timing
- Reset (rst_i low, asynchronous): all regs = 0, all cnt = 0, value0_o = value1_o = 0, overflow_o = 0. hazard_o is therefore 0 during reset.
- Read latency is 1 cycle. Write-to-read with the same index in the same cycle returns new data at the next edge (0-cycle visibility via bypass).
- Retire-to-unstall: hazard_o deasserts in the same cycle as the retiring writeback when it is the last pending write. The bypassed value appears on value*_o at the next edge.
- Both read ports may name the same register, and both see identical data.
- Deassertion of rst_i is synchronised externally; no reset-release logic is required internally.

## Test plan
- Reset: hold rst_i low mid-run after writing regs[5]=0xDEADBEEF. Then read r5 -> value0_o=0, hazard_o=0, overflow_o=0.
- Write/read bypass: in one cycle, we=1, idx=3, result=0x12345678, reg0=reg1=3 -> both value outputs are 0x12345678 one edge later. Read r3 again -> same value.
- Scoreboard stall: reserve r7. Next cycle read r7 -> hazard_o=1. Writeback r7=0xA5A5A5A5 while still reading r7 -> hazard_o=0 that cycle, value0_o=0xA5A5A5A5 at the next edge.
- Multiple pending writes: reserve r2 three times, then retire twice -> hazard_o remains 1. The third retire clears it. A fourth reserve while at 3 sets overflow_o=1 and it stays set.
- Simultaneous events: reserve and retire r4 in the same cycle with cnt=1 -> cnt stays 1 and hazard_o=1 next cycle. An unreserved write to r9 with cnt=0 -> data written, cnt stays 0.
- Flush: reserve r1 and r6, then flush_i=1 alongside a writeback of r6=0x55 -> all counts are 0 next cycle, hazard_o=0 reading r1/r6, and r6 reads 0x55.
